qmac_vec: RTL and testbench
===========================

QMAC_VEC -- requirements
Module: qmac_vec

Interface
REQ-001 Parameter Q, default 5: fractional bits of each signed input operand.
REQ-002 Parameter N, default 8: total width of each signed input operand.
REQ-003 Parameter LEN, default 4, legal range 1..1024: number of element pairs per dot product.
REQ-004 Parameter ACC_W, default 2*N+clog2(LEN): accumulator width; ACC_W less than 2*N+clog2(LEN) SHALL fail elaboration.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 clr  in  1  synchronous abort of the partial vector in progress.
REQ-008 in_valid  in  1  a and b hold a valid element pair.
REQ-009 in_ready  out  1  block accepts a pair this cycle.
REQ-010 a  in  N  signed two's-complement operand, Q fractional bits.
REQ-011 b  in  N  signed two's-complement operand, Q fractional bits.
REQ-012 out_valid  out  1  out_data and out_ovf hold a finished dot product.
REQ-013 out_ready  in  1  downstream accepts the result.
REQ-014 out_data  out  2*N  signed result, 2*Q fractional bits, saturated.
REQ-015 out_ovf  out  1  the result in out_data was saturated.

Function
REQ-016 Stall: en = !(out_valid && !out_ready); in_ready SHALL equal en && !clr.
REQ-017 A pair is accepted on any rising edge where in_valid && in_ready.
REQ-018 Stage 1 SHALL register the exact signed product a*b (2*N bits, 2*Q fractional bits) together with a valid bit and a last bit.
REQ-019 Stage 2 SHALL add the sign-extended product to the ACC_W accumulator; the first element of a vector SHALL load the product instead of adding it.
REQ-020 Stage-1 and stage-2 registers SHALL advance only when en=1; when en=0 they SHALL hold.
REQ-021 Element counter cnt counts 0..LEN-1 on each accepted pair; on an accepted pair with cnt=LEN-1 it SHALL wrap to 0 and mark that pair last.
REQ-022 When the last product is accumulated, the final sum SHALL be saturated to 2*N signed bits into out_data.
REQ-023 In the same update, out_ovf SHALL be set to 1 if saturation occurred and 0 otherwise, and out_valid SHALL be set.
REQ-024 Latency: if the last pair is accepted at edge t and there is no stall, out_valid SHALL be 1 after edge t+2.
REQ-025 out_valid SHALL clear on the edge where out_valid && out_ready, unless a new result completes on that same edge, in which case the new result SHALL load.
REQ-026 Throughput: one pair per cycle, and back-to-back vectors with no gap cycle.
REQ-027 clr=1: cnt SHALL be set to 0, both pipeline valid bits SHALL clear, and no pair is accepted; a pending out_valid/out_data SHALL be unaffected.
REQ-028 With LEN=1, every accepted pair SHALL produce a result.
REQ-029 The accumulator SHALL never wrap, because ACC_W is sized for the worst case.

Reset
REQ-030 When reset_n=0, asynchronously: cnt=0, pipeline valid and last bits=0, accumulator=0, out_valid=0, out_data=0, out_ovf=0.
REQ-031 In-flight data is discarded on reset; in_ready SHALL equal 1 from the first edge after reset_n rises.

Structure
REQ-032 Package qmac_pkg SHALL hold the accumulator-width function, the saturation bounds (2^(2N-1)-1 and -2^(2N-1)), and the LEN range check.
REQ-033 Sub-module qmac_sat SHALL implement the combinational saturation from ACC_W to 2*N bits, with an overflow flag.
REQ-034 The top level SHALL hold the counter, the stall logic, both pipeline stages and the output register.

Verification (Q=5, N=8, LEN=4, out_ready=1 unless stated)
REQ-035 Four pairs a=b=32 (1.0) -> out_data=16'h1000 (4.0 in Q10), out_ovf=0, out_valid two cycles after the 4th pair.
REQ-036 Pairs (32,32), (32,-32), (127,127), (0,0) -> out_data=16'h3F01 (16129), out_ovf=0.
REQ-037 Four pairs a=b=127 -> sum 64516 -> out_data=16'h7FFF, out_ovf=1; four pairs a=-128, b=127 -> out_data=16'h8000, out_ovf=1.
REQ-038 Two vectors back-to-back with out_ready=0 -> in_ready drops while the first result is held, the second result is not lost, and both are delivered in order once out_ready=1.
REQ-039 clr after 2 pairs, then four pairs a=b=32 -> out_data=16'h1000.
REQ-040 reset_n=0 mid-vector -> all outputs 0 immediately; the next full vector produces a correct result.

Source files
------------

// File: rtl/qmac_pkg.sv
// qmac_pkg: shared sizing, range and saturation helpers for the Q-format dot-product MAC
package qmac_pkg;

  localparam int LEN_MIN = 1;
  localparam int LEN_MAX = 1024;

  // Smallest accumulator that can hold LEN full-scale products without wrapping
  function automatic int acc_width(input int n, input int len);
    return 2 * n + $clog2(len);
  endfunction

  function automatic bit len_ok(input int len);
    return len >= LEN_MIN && len <= LEN_MAX;
  endfunction

  // Largest positive value of a w-bit signed word, 2^(w-1)-1 (truncate to w bits at use)
  function automatic logic [63:0] sat_hi(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative value of a w-bit signed word, -2^(w-1) (truncate to w bits at use)
  function automatic logic [63:0] sat_lo(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/qmac_sat.sv
// qmac_sat: combinational saturation of the wide accumulator down to 2*N signed bits
module qmac_sat
  import qmac_pkg::*;
#(
  parameter int N     = 8,
  parameter int ACC_W = 18
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic        [2*N-1:0]   sat_o,
  output logic                    ovf_o
);

  localparam int W = 2 * N;

  // Bits above the result's sign bit must all equal it, otherwise the sum does not fit
  logic [ACC_W-W:0] top;

  // Clamp toward the sign of the wide sum when the upper bits disagree
  always_comb begin
    top   = acc_i[ACC_W-1:W-1];
    ovf_o = !(&top || !(|top));
    sat_o = ovf_o ? (acc_i[ACC_W-1] ? W'(sat_lo(W)) : W'(sat_hi(W))) : acc_i[W-1:0];
  end

endmodule

// File: rtl/qmac_vec.sv
// qmac_vec: streaming signed Q-format dot product, two pipeline stages plus a saturated output register
module qmac_vec
  import qmac_pkg::*;
#(
  parameter int Q     = 5,
  parameter int N     = 8,
  parameter int LEN   = 4,
  parameter int ACC_W = acc_width(N, LEN)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [N-1:0]   a,
  input  logic signed [N-1:0]   b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic        [2*N-1:0] out_data,
  output logic                  out_ovf
);

  localparam int W  = 2 * N;
  localparam int CW = LEN > 1 ? $clog2(LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  if (!len_ok(LEN)) begin : g_len_chk
    $error("qmac_vec: LEN out of range 1..1024");
  end
  if (ACC_W < acc_width(N, LEN)) begin : g_acc_chk
    $error("qmac_vec: ACC_W too narrow for worst-case sum");
  end
  if (Q < 0 || Q > N) begin : g_q_chk
    $error("qmac_vec: Q must lie in 0..N");
  end

  logic                 en, accept, done, sat_ovf;
  logic [W-1:0]         sat;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 p_valid_q, p_valid_d, p_last_q, p_last_d, p_first_q, p_first_d;
  logic signed [W-1:0]  p_q, p_d;
  logic                 s_valid_q, s_valid_d, s_last_q, s_last_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                 out_valid_q, out_valid_d, out_ovf_q, out_ovf_d;
  logic [W-1:0]         out_data_q, out_data_d;

  qmac_sat #(.N(N), .ACC_W(ACC_W)) u_sat (
    .acc_i (acc_q),
    .sat_o (sat),
    .ovf_o (sat_ovf)
  );

  // Next-state for counter, both pipeline stages and the output register; everything freezes on a held result
  always_comb begin
    en          = !(out_valid_q && !out_ready);
    in_ready    = en && !clr;
    accept      = in_valid && in_ready;
    done        = s_valid_q && s_last_q;
    cnt_d       = clr ? '0 : !accept ? cnt_q : cnt_q == LAST ? '0 : cnt_q + 1'b1;
    p_valid_d   = clr ? 1'b0 : en ? accept : p_valid_q;
    p_last_d    = en ? accept && cnt_q == LAST : p_last_q;
    p_first_d   = en ? cnt_q == '0 : p_first_q;
    p_d         = en ? W'(a) * W'(b) : p_q;
    s_valid_d   = clr ? 1'b0 : en ? p_valid_q : s_valid_q;
    s_last_d    = en ? p_last_q : s_last_q;
    acc_d       = !(en && p_valid_q) ? acc_q : p_first_q ? ACC_W'(p_q) : acc_q + ACC_W'(p_q);
    out_valid_d = (en && done) ? 1'b1 : (out_valid_q && out_ready) ? 1'b0 : out_valid_q;
    out_data_d  = (en && done) ? sat : out_data_q;
    out_ovf_d   = (en && done) ? sat_ovf : out_ovf_q;
  end

  // State registers; reset discards any vector in flight and any pending result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      p_valid_q   <= 1'b0;
      p_last_q    <= 1'b0;
      p_first_q   <= 1'b0;
      p_q         <= '0;
      s_valid_q   <= 1'b0;
      s_last_q    <= 1'b0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      p_valid_q   <= p_valid_d;
      p_last_q    <= p_last_d;
      p_first_q   <= p_first_d;
      p_q         <= p_d;
      s_valid_q   <= s_valid_d;
      s_last_q    <= s_last_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_qmac_vec.sv
// tb_qmac_vec: directed table-driven bench for qmac_vec at Q=5, N=8, LEN=4
module tb_qmac_vec;

  logic clk = 1'b0, reset_n = 1'b0, clr = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic signed [7:0] a = '0, b = '0;
  logic in_ready, out_valid, out_ovf;
  logic [15:0] out_data;

  int checks = 0, errors = 0;
  logic [16:0] q[$];

  typedef struct {
    logic [3:0][7:0] av;
    logic [3:0][7:0] bv;
    logic [15:0]     d;
    logic            o;
  } vec_t;

  vec_t vecs[7];

  qmac_vec #(.Q(5), .N(8), .LEN(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  // Record every result that will transfer on the coming rising edge
  always begin
    @(negedge clk);
    #2;
    if (out_valid && out_ready) q.push_back({out_ovf, out_data});
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=running req=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h req=%h", n, act, exp);
    end
  endtask

  // Present one pair from a falling edge and hold it until the rising edge that accepts it
  task automatic feed(input logic [7:0] av, input logic [7:0] bv);
    int g = 0;
    bit ok = 0;
    @(negedge clk);
    in_valid = 1'b1;
    a = av;
    b = bv;
    while (!ok) begin
      #1;
      ok = in_ready;
      @(posedge clk);
      if (!ok) begin
        g++;
        if (g > 200) begin
          chk("feed_timeout", 0, 1);
          in_valid = 1'b0;
          return;
        end
        @(negedge clk);
      end
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic feed_vec(input vec_t v);
    for (int j = 3; j >= 0; j--) feed(v.av[j], v.bv[j]);
  endtask

  task automatic wait_out();
    for (int k = 0; k < 20 && !out_valid; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    vecs[0] = '{av: {8'd32, 8'd32, 8'd32, 8'd32}, bv: {8'd32, 8'd32, 8'd32, 8'd32}, d: 16'h1000, o: 1'b0};
    vecs[1] = '{av: {8'd32, 8'd32, 8'd127, 8'd0}, bv: {8'd32, 8'hE0, 8'd127, 8'd0}, d: 16'h3F01, o: 1'b0};
    vecs[2] = '{av: {8'd127, 8'd127, 8'd127, 8'd127}, bv: {8'd127, 8'd127, 8'd127, 8'd127}, d: 16'h7FFF, o: 1'b1};
    vecs[3] = '{av: {8'h80, 8'h80, 8'h80, 8'h80}, bv: {8'd127, 8'd127, 8'd127, 8'd127}, d: 16'h8000, o: 1'b1};
    vecs[4] = '{av: {8'h80, 8'h80, 8'h80, 8'h80}, bv: {8'd64, 8'd64, 8'd64, 8'd64}, d: 16'h8000, o: 1'b0};
    vecs[5] = '{av: {8'h80, 8'hFF, 8'd0, 8'd0}, bv: {8'h80, 8'd1, 8'd0, 8'd0}, d: 16'h3FFF, o: 1'b0};
    vecs[6] = '{av: {8'hE0, 8'hE0, 8'hE0, 8'hE0}, bv: {8'd32, 8'd32, 8'd32, 8'd32}, d: 16'hF000, o: 1'b0};

    #2;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_ovf", 32'(out_ovf), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);

    for (int i = 0; i < 7; i++) begin
      feed_vec(vecs[i]);
      chk($sformatf("v%0d_lat0", i), 32'(out_valid), 0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_lat1", i), 32'(out_valid), 0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_lat2", i), 32'(out_valid), 1);
      chk($sformatf("v%0d_data", i), 32'(out_data), 32'(vecs[i].d));
      chk($sformatf("v%0d_ovf", i), 32'(out_ovf), 32'(vecs[i].o));
    end

    @(posedge clk);
    #1;
    chk("pop_clears_valid", 32'(out_valid), 0);

    q.delete();
    out_ready = 1'b0;
    fork
      begin
        feed_vec(vecs[0]);
        feed_vec(vecs[1]);
      end
      begin
        repeat (8) @(posedge clk);
        #1;
        chk("bp_in_ready_low", 32'(in_ready), 0);
        chk("bp_held_valid", 32'(out_valid), 1);
        chk("bp_held_data", 32'(out_data), 32'h1000);
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    for (int k = 0; k < 30 && q.size() < 2; k++) @(posedge clk);
    chk("bp_count", 32'(q.size()), 2);
    if (q.size() >= 2) begin
      chk("bp_first", 32'(q[0]), 32'h01000);
      chk("bp_second", 32'(q[1]), 32'h03F01);
    end

    repeat (3) @(posedge clk);
    q.delete();
    feed(8'd127, 8'd127);
    feed(8'd127, 8'd127);
    @(negedge clk);
    clr = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("clr_in_ready", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    in_valid = 1'b0;
    feed_vec(vecs[0]);
    wait_out();
    chk("clr_valid", 32'(out_valid), 1);
    chk("clr_data", 32'(out_data), 32'h1000);
    @(posedge clk);
    #1;
    chk("clr_result_count", 32'(q.size()), 1);

    out_ready = 1'b0;
    feed_vec(vecs[0]);
    feed(8'd127, 8'd127);
    @(posedge clk);
    #1;
    chk("mid_pending_valid", 32'(out_valid), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_data", 32'(out_data), 0);
    chk("mid_rst_ovf", 32'(out_ovf), 0);
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_in_ready", 32'(in_ready), 1);
    feed_vec(vecs[1]);
    wait_out();
    chk("mid_after_valid", 32'(out_valid), 1);
    chk("mid_after_data", 32'(out_data), 32'h3F01);
    chk("mid_after_ovf", 32'(out_ovf), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
